i2s_rx_param: RTL and testbench

I2S_RX_PARAM -- requirements
Module: i2s_rx_param

---
 rtl/i2s_rx_param.sv | 105 ++++++++++
 tb/tb_i2s_rx_param.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_param.sv
// I2S / left-justified serial audio receiver: generates bck/lrck from clk and deserialises din into left/right.
// Both samples are presented together at the frame wrap; valid/ready handshake, with overwrite flagged as sticky overrun.
module i2s_rx_param #(
  parameter int DATA_W  = 24,
  parameter int SLOT_W  = 32,
  parameter int BCK_DIV = 2,
  parameter int MODE    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              din,
  input  logic              ready,
  output logic              scki,
  output logic              bck,
  output logic              lrck,
  output logic [DATA_W-1:0] left,
  output logic [DATA_W-1:0] right,
  output logic              valid,
  output logic              overrun
);

  localparam int DELAY = (MODE == 0) ? 1 : 0;
  localparam int DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam int CNT_W = $clog2(2 * SLOT_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_W - 1);
  localparam logic [CNT_W-1:0] SLOT_N   = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] FIRST    = CNT_W'(DELAY);
  localparam logic [CNT_W-1:0] DATA_N   = CNT_W'(DATA_W);

  logic [DIV_W-1:0]  div;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W-1:0]  sbit;
  logic [CNT_W-1:0]  sbit_off;
  logic [DATA_W-1:0] sh_l;
  logic [DATA_W-1:0] sh_r;
  logic              tick;
  logic              rise;
  logic              fall;
  logic              wrap;
  logic              capture;

  assign scki = clk;

  always_comb begin
    tick     = en && (div == DIV_LAST);
    rise     = tick && !bck;
    fall     = tick && bck;
    wrap     = fall && (cnt == CNT_LAST);
    cnt_nxt  = wrap ? '0 : cnt + 1'b1;
    sbit     = lrck ? cnt - SLOT_N : cnt;
    // Bits before the data window wrap to a large value and fall outside it.
    sbit_off = sbit - FIRST;
    capture  = rise && (sbit_off < DATA_N);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div     <= '0;
      cnt     <= '0;
      bck     <= 1'b0;
      lrck    <= 1'b0;
      sh_l    <= '0;
      sh_r    <= '0;
      left    <= '0;
      right   <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (!en) begin
        div  <= '0;
        cnt  <= '0;
        bck  <= 1'b0;
        lrck <= 1'b0;
        sh_l <= '0;
        sh_r <= '0;
      end else begin
        div <= tick ? '0 : div + 1'b1;
        if (tick) bck <= ~bck;
        if (fall) begin
          cnt  <= cnt_nxt;
          lrck <= (cnt_nxt >= SLOT_N);
        end
        if (capture) begin
          if (lrck) sh_r <= {sh_r[DATA_W-2:0], din};
          else      sh_l <= {sh_l[DATA_W-2:0], din};
        end
      end

      // The handshake keeps running while en is low; only wrap needs en.
      if (wrap) begin
        left  <= sh_l;
        right <= sh_r;
        valid <= 1'b1;
        if (valid && !ready) overrun <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_param.sv
// Bench for i2s_rx_param: an I2S and a left-justified instance fed the same sample stream,
// compared every cycle against a frame-timing model plus a directed table of frames.
module tb_i2s_rx_param;
  localparam int DATA_W  = 24;
  localparam int SLOT_W  = 32;
  localparam int BCK_DIV = 2;
  localparam int FRAME   = 4 * SLOT_W * BCK_DIV;

  logic clk = 1'b0;
  logic reset, en, din0, din1, ready;
  logic scki0, bck0, lrck0, valid0, overrun0;
  logic scki1, bck1, lrck1, valid1, overrun1;
  logic [DATA_W-1:0] left0, right0, left1, right1;

  always #5 clk = ~clk;

  i2s_rx_param #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .BCK_DIV(BCK_DIV), .MODE(0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .din(din0), .ready(ready),
    .scki(scki0), .bck(bck0), .lrck(lrck0), .left(left0), .right(right0),
    .valid(valid0), .overrun(overrun0));

  i2s_rx_param #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .BCK_DIV(BCK_DIV), .MODE(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .din(din1), .ready(ready),
    .scki(scki1), .bck(bck1), .lrck(lrck1), .left(left1), .right(right1),
    .valid(valid1), .overrun(overrun1));

  typedef struct {
    logic [DATA_W-1:0] l_in;
    logic [DATA_W-1:0] r_in;
    logic              hold;
    logic [DATA_W-1:0] exp_l;
    logic [DATA_W-1:0] exp_r;
    logic              exp_v;
    logic              exp_o;
  } vec_t;

  vec_t vecs[4];

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] fr_l[64];
  logic [DATA_W-1:0] fr_r[64];
  logic [63:0]       fill[64];

  // Model: ecnt = clk edges seen with en high since the last enable/reset.
  int                ecnt;
  logic [DATA_W-1:0] m_l, m_r;
  logic              m_v, m_o, m_upd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic stream_bit(input int pos, input int delay);
    int f, p, s, d;
    f = (pos / (2 * SLOT_W)) % 64;
    p = pos % (2 * SLOT_W);
    s = p % SLOT_W;
    d = s - delay;
    if (d >= 0 && d < DATA_W)
      return (p >= SLOT_W) ? fr_r[f][DATA_W-1-d] : fr_l[f][DATA_W-1-d];
    return fill[f][p];
  endfunction

  task automatic new_frames();
    for (int i = 0; i < 64; i++) begin
      fr_l[i] = DATA_W'($urandom);
      fr_r[i] = DATA_W'($urandom);
      fill[i] = {$urandom, $urandom};
    end
  endtask

  task automatic check_outputs();
    logic eb, elr;
    eb  = 1'((ecnt / BCK_DIV) % 2);
    elr = 1'((ecnt / (2 * BCK_DIV * SLOT_W)) % 2);
    chk("bck0",     32'(bck0),     32'(eb));
    chk("lrck0",    32'(lrck0),    32'(elr));
    chk("valid0",   32'(valid0),   32'(m_v));
    chk("overrun0", 32'(overrun0), 32'(m_o));
    chk("left0",    32'(left0),    32'(m_l));
    chk("right0",   32'(right0),   32'(m_r));
    chk("bck1",     32'(bck1),     32'(eb));
    chk("lrck1",    32'(lrck1),    32'(elr));
    chk("valid1",   32'(valid1),   32'(m_v));
    chk("overrun1", 32'(overrun1), 32'(m_o));
    chk("left1",    32'(left1),    32'(m_l));
    chk("right1",   32'(right1),   32'(m_r));
    chk("scki0",    32'(scki0),    32'(clk));
    chk("scki1",    32'(scki1),    32'(clk));
  endtask

  task automatic tick();
    int n, f;
    n = (!reset || !en) ? 0 : ecnt + 1;
    // Bit k of the frame is sampled on edge BCK_DIV + k*2*BCK_DIV.
    if (n >= BCK_DIV) begin
      din0 = stream_bit((n - BCK_DIV) / (2 * BCK_DIV), 1);
      din1 = stream_bit((n - BCK_DIV) / (2 * BCK_DIV), 0);
    end else begin
      din0 = 1'($urandom);
      din1 = 1'($urandom);
    end
    m_upd = 1'b0;
    if (!reset) begin
      ecnt = 0; m_l = '0; m_r = '0; m_v = 1'b0; m_o = 1'b0;
    end else begin
      ecnt = n;
      if (n > 0 && n % FRAME == 0) begin
        m_upd = 1'b1;
        f = (n / FRAME - 1) % 64;
        if (m_v && !ready) m_o = 1'b1;
        m_v = 1'b1;
        m_l = fr_l[f];
        m_r = fr_r[f];
      end else if (m_v && ready) begin
        m_v = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic run_until_wrap(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < FRAME + 20; k++) begin
      tick();
      if (m_upd) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic rand_ticks(input int cnt);
    for (int k = 0; k < cnt; k++) begin
      ready = ($urandom_range(0, 7) == 0);
      tick();
    end
    ready = 1'b0;
  endtask

  initial begin
    logic ok;
    reset = 1'b0; en = 1'b1; ready = 1'b0; din0 = 1'b0; din1 = 1'b0;
    ecnt = 0; m_l = '0; m_r = '0; m_v = 1'b0; m_o = 1'b0; m_upd = 1'b0;
    new_frames();

    vecs[0] = '{24'hA5A5A5, 24'h123456, 1'b0, 24'hA5A5A5, 24'h123456, 1'b1, 1'b0};
    vecs[1] = '{24'h800000, 24'h7FFFFF, 1'b0, 24'h800000, 24'h7FFFFF, 1'b1, 1'b0};
    vecs[2] = '{24'hFFFFFF, 24'h000000, 1'b1, 24'hFFFFFF, 24'h000000, 1'b1, 1'b0};
    vecs[3] = '{24'h000001, 24'hFFFFFF, 1'b0, 24'h000001, 24'hFFFFFF, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      fr_l[i] = vecs[i].l_in;
      fr_r[i] = vecs[i].r_in;
    end

    #1;
    check_outputs();
    repeat (10) tick();
    reset = 1'b1;

    tick();
    chk("bck_pre_rise", 32'(bck0), 32'd0);
    tick();
    chk("bck_first_rise", 32'(bck0), 32'd1);
    while (ecnt < FRAME / 2 - 1) tick();
    chk("lrck_low_127", 32'(lrck0), 32'd0);
    tick();
    chk("lrck_high_128", 32'(lrck0), 32'd1);

    for (int i = 0; i < 4; i++) begin
      run_until_wrap(ok);
      chk("vec_wrap_seen", 32'(ok), 32'd1);
      chk("vec_left0",    32'(left0),    32'(vecs[i].exp_l));
      chk("vec_right0",   32'(right0),   32'(vecs[i].exp_r));
      chk("vec_left1",    32'(left1),    32'(vecs[i].exp_l));
      chk("vec_right1",   32'(right1),   32'(vecs[i].exp_r));
      chk("vec_valid",    32'(valid0),   32'(vecs[i].exp_v));
      chk("vec_overrun",  32'(overrun0), 32'(vecs[i].exp_o));
      if (!vecs[i].hold) begin
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("ready_clears_valid", 32'(valid0), 32'd0);
        chk("overrun_after_ready", 32'(overrun1), 32'(vecs[i].exp_o));
      end
    end

    rand_ticks(3 * FRAME);

    // Drop en just after the bit counter reaches 10.
    while (ecnt % FRAME != 4 * BCK_DIV * 5 + 1) tick();
    en = 1'b0;
    tick();
    chk("en_off_bck",  32'(bck0),  32'd0);
    chk("en_off_lrck", 32'(lrck0), 32'd0);
    rand_ticks(19);
    en = 1'b1;
    new_frames();
    run_until_wrap(ok);
    chk("gap_wrap_seen", 32'(ok), 32'd1);
    chk("gap_left",  32'(left0),  32'(fr_l[0]));
    chk("gap_right", 32'(right1), 32'(fr_r[0]));
    rand_ticks(FRAME + 100);

    // Asynchronous reset between clock edges.
    #2;
    reset = 1'b0;
    #1;
    ecnt = 0; m_l = '0; m_r = '0; m_v = 1'b0; m_o = 1'b0;
    check_outputs();
    repeat (3) tick();
    reset = 1'b1;
    new_frames();
    rand_ticks(2 * FRAME + 10);
    chk("post_reset_left", 32'(left0), 32'(fr_l[1]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
